ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

PS/2 keyboard receiver and scan-code buffer feeding the MMIO keyboard port. Deserialises 11-bit PS/2 device-to-host frames from the raw `ps2_clk`/`ps2_data` pins, buffers complete bytes in a small FIFO, and presents the head byte on `kbd_data` with `kbd_ready`/`kbd_overflow` status. It sits directly upstream of the MMIO block, which pulses `kbd_read_enable` to consume the head byte.

## Interface
- `FIFO_AW`, 3: log2 of FIFO depth (8 entries).
- `TIMEOUT`, 50000: clk cycles without a falling `ps2_clk` edge before a partial frame is abandoned.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin; asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin; asynchronous to `clk`.
- `kbd_read_enable` input 1: one-cycle pop strobe from MMIO.
- `kbd_ready` output 1: FIFO non-empty.
- `kbd_overflow` output 1: sticky flag, set when a byte was lost.
- `kbd_data` output 8: FIFO head byte; 0 when empty.

## Operation
- Sync: two-flop synchronisers on both pins, plus a third flop on `ps2_clk` for edge detection. `fall` = previous synced clk high and current synced clk low. All FSM actions occur on `clk` edges where `fall`=1, sampling synced data.
- FSM states:
  - IDLE: on `fall` with data=0 (start bit) → DATA, bit count 0; on data=1 stay in IDLE (glitch).
  - DATA: shift data into bit [7], shifting right (LSB first); after the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: if data=1 and the frame is valid, push the byte; → IDLE in all cases.
- Frame valid: stop bit = 1 (plus parity rule under Configuration). Invalid frames are dropped silently and do not set `kbd_overflow`.
- Timeout: in any non-IDLE state, a counter increments each cycle and clears on `fall`. When it reaches `TIMEOUT`-1, go to IDLE and discard the partial byte.
- Pop: `kbd_read_enable`=1 with FIFO non-empty advances the read pointer. Pop when empty is ignored.
- Push to a full FIFO drops the new byte and sets `kbd_overflow`. Stored contents are unchanged.
- Push and pop in the same cycle:
  - FIFO full: both succeed; count unchanged; no overflow.
  - FIFO empty: only the push takes effect.
- `kbd_overflow` clears on any successful pop. If a pop and an overflowing push coincide, the pop wins and no overflow occurs (see above).
- Pointers are `FIFO_AW`+1 bits, wrapping modulo 2·depth. Full = MSBs differ and low bits equal.

## Timing
- Reset values: `kbd_ready`=0, `kbd_overflow`=0, `kbd_data`=0, FSM=IDLE, pointers=0, shift register=0, timeout counter=0.
- Reset mid-frame aborts the frame immediately; FIFO contents are lost.
- Pin-to-`fall` latency: 3 clk from the pin falling edge.
- A push on clock edge N makes `kbd_ready`=1 and `kbd_data` valid in cycle N+1.
- `kbd_data` is combinational from the FIFO head. It stays stable until the cycle after a pop.
- After a pop at edge N, the next head byte (or 0 if empty) appears in cycle N+1.
- MMIO samples `kbd_data` during its load cycle and strobes `kbd_read_enable` one cycle later. The byte must therefore stay at the head across that gap, which it does because no pop occurs in between.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the frame is valid only if the 8 data bits plus the parity bit have odd total parity; otherwise it is dropped.
- Not defined: the parity bit is received and ignored, so only the stop bit is checked.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_DATA_BITS`=8.
  - `PS2_FRAME_BITS`=11.
- Sub-module `kbd_fifo`: synchronous FIFO parameterised by `FIFO_AW`, 8-bit width. Ports: push, pop, wdata, rdata, empty, full.
- Synchroniser, edge detector, FSM, timeout counter and overflow flag live in `ps2_kbd_rx`.

## Test plan
- Single frame: send 0x1C (start 0, bits LSB first, parity 0, stop 1) with `ps2_clk` period 2000 clk → `kbd_ready`=1 and `kbd_data`=0x1C one cycle after the stop-bit `fall`; pulse `kbd_read_enable` → `kbd_ready`=0 and `kbd_data`=0 next cycle.
- Ordering and wrap: send 0x01…0x05, pop all, send 0x06…0x0D, pop all → bytes return in order and pointer wrap is exercised.
- Overflow: send 9 bytes with no pop → `kbd_overflow`=1, FIFO holds the first 8; one pop → `kbd_overflow`=0 and head=2nd byte. Then simultaneous push and pop while full → no overflow.
- Parity (macro on): frame 0x1C with parity 1 → no push, `kbd_ready` stays 0. Same frame with macro off → 0x1C pushed.
- Timeout: send start + 4 bits, hold `ps2_clk` high for `TIMEOUT`+5 cycles, then a full 0x2A frame → only 0x2A received.
- Async reset: assert `rst`=0 mid-frame with 3 bytes buffered → all outputs 0 immediately; after release, a new frame 0x55 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_e    : receive FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_DATA_BITS  : payload bits per frame
//   - PS2_FRAME_BITS : total bits per device-to-host frame (start+8+parity+stop)
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage : ps2_pkg

// File: rtl/kbd_fifo.sv
// ---------------------------------------------------------------------------
// kbd_fifo
// Synchronous byte FIFO, 2**FIFO_AW entries, with a combinational head.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : write strobe and byte; ignored when full unless a pop
//                   is accepted in the same cycle
//   pop           : read strobe; ignored when empty
//   rdata         : head byte, 0 when empty
//   empty, full   : occupancy status
// ---------------------------------------------------------------------------
module kbd_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PS2_DATA_BITS-1:0] wdata,
  output logic [PS2_DATA_BITS-1:0] rdata,
  output logic                     empty,
  output logic                     full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]         wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]         rd_ptr_q, rd_ptr_d;
  logic                     do_push;
  logic                     do_pop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // A pop frees the slot a full-FIFO push writes into, so both proceed.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers already mask
  // stale entries and rdata reads 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[FIFO_AW-1:0]] <= wdata;
  end

endmodule : kbd_fifo

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 device-to-host frame receiver feeding a scan-code FIFO.
// Optional feature: define PS2_PARITY_CHECK_EN to drop frames whose data
// bits plus parity bit do not have odd parity.
// Ports:
//   clk, rst          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : raw PS/2 pins, asynchronous to clk
//   kbd_read_enable   : one-cycle pop strobe
//   kbd_ready         : FIFO non-empty
//   kbd_overflow      : sticky, a byte was lost; cleared by a successful pop
//   kbd_data          : FIFO head byte, 0 when empty
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     kbd_read_enable,
  output logic                     kbd_ready,
  output logic                     kbd_overflow,
  output logic [PS2_DATA_BITS-1:0] kbd_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Synchronisers; reset to the idle-high pin level so release cannot
  // fabricate a falling edge.
  logic pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic pdat_s1_q, pdat_s2_q;
  logic fall;

  ps2_state_e               state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     ovf_q, ovf_d;
  logic                     frame_valid;
  logic                     push;
  logic                     fifo_empty, fifo_full;
  logic                     pop_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign frame_valid = ^{shift_q, parity_q};
`else
  assign frame_valid = 1'b1;
`endif

  assign fall   = pclk_s3_q & ~pclk_s2_q;
  assign pop_ok = kbd_read_enable & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    tmo_d     = (state_q == IDLE) ? '0 : tmo_q + 1'b1;

    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          // A high sample at a falling edge is a glitch, not a start bit.
          if (!pdat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        DATA: begin
          shift_d = {pdat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
          else                                     bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = pdat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          push    = pdat_s2_q & frame_valid;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      // Device stopped clocking mid-frame: abandon the partial byte.
      state_d   = IDLE;
      tmo_d     = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end

    // A coinciding pop makes room, so it both clears and prevents overflow.
    ovf_d = ovf_q;
    if (pop_ok)                  ovf_d = 1'b0;
    else if (push && fifo_full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_s1_q <= 1'b1;
      pclk_s2_q <= 1'b1;
      pclk_s3_q <= 1'b1;
      pdat_s1_q <= 1'b1;
      pdat_s2_q <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      pclk_s1_q <= ps2_clk;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      pdat_s1_q <= ps2_data;
      pdat_s2_q <= pdat_s1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  kbd_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (kbd_read_enable),
    .wdata (shift_q),
    .rdata (kbd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kbd_ready    = ~fifo_empty;
  assign kbd_overflow = ovf_q;

endmodule : ps2_kbd_rx

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Directed bench for ps2_kbd_rx: a table of send/pop operations with
// hand-computed FIFO state, plus hand-written sequences for push latency,
// timeout recovery and asynchronous reset mid-frame.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int TMO = 200;   // short timeout keeps the run brief
  localparam int H   = 8;     // PS/2 half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kbd_read_enable = 1'b0;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic [7:0] kbd_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .kbd_read_enable (kbd_read_enable),
    .kbd_ready       (kbd_ready),
    .kbd_overflow    (kbd_overflow),
    .kbd_data        (kbd_data)
  );

  always #5 clk = ~clk;

  typedef enum {OP_SEND, OP_POP, OP_SEND_POP, OP_BADPAR, OP_BADSTOP} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] val;
    logic       exp_ready;
    logic       exp_ovf;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame bits in send order: start, d0..d7, parity (odd), stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_flip,
                                             input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; optionally pops on the push edge of
  // the stop bit (third clk edge after the pin falls).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        repeat (2) @(posedge clk);
        #1 kbd_read_enable = 1'b1;
        @(posedge clk);
        #1 kbd_read_enable = 1'b0;
        repeat (H - 3) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_pop();
    @(posedge clk); #1 kbd_read_enable = 1'b1;
    @(posedge clk); #1 kbd_read_enable = 1'b0;
  endtask

  function automatic vec_t mk(input op_e op, input logic [7:0] val, input logic r,
                              input logic o, input logic [7:0] d);
    vec_t v;
    v.op = op; v.val = val; v.exp_ready = r; v.exp_ovf = o; v.exp_data = d;
    return v;
  endfunction

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // --- table ---
    for (int b = 1; b <= 5; b++) vecs.push_back(mk(OP_SEND, 8'(b), 1, 0, 8'h01));
    for (int b = 2; b <= 5; b++) vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 8'(b)));
    vecs.push_back(mk(OP_POP, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(OP_POP, 8'h00, 0, 0, 8'h00));          // pop while empty
    for (int b = 6; b <= 13; b++) vecs.push_back(mk(OP_SEND, 8'(b), 1, 0, 8'h06));
    vecs.push_back(mk(OP_SEND, 8'h0E, 1, 1, 8'h06));         // 9th byte lost
    vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 8'h07));
    vecs.push_back(mk(OP_SEND, 8'h0F, 1, 0, 8'h07));         // full again
    vecs.push_back(mk(OP_SEND_POP, 8'h10, 1, 0, 8'h08));     // push+pop while full
    for (int b = 9; b <= 13; b++) vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 8'(b)));
    vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 8'h0F));
    vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 8'h10));
    vecs.push_back(mk(OP_POP, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(OP_BADSTOP, 8'h33, 0, 0, 8'h00));
`ifdef PS2_PARITY_CHECK_EN
    vecs.push_back(mk(OP_BADPAR, 8'h1C, 0, 0, 8'h00));
`else
    vecs.push_back(mk(OP_BADPAR, 8'h1C, 1, 0, 8'h1C));
`endif
    vecs.push_back(mk(OP_POP, 8'h00, 0, 0, 8'h00));

    // --- reset state ---
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {kbd_ready, kbd_overflow, kbd_data}, 10'h000);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // --- single frame with exact push latency ---
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 10, 1'b0);
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("latency_before_push", {31'd0, kbd_ready}, 32'd0);
    @(posedge clk);
    #1 check("latency_push", {kbd_ready, kbd_overflow, kbd_data}, {2'b10, 8'h1C});
    repeat (H - 3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    do_pop();
    check("single_pop", {kbd_ready, kbd_overflow, kbd_data}, 10'h000);

    // --- table-driven operations ---
    for (int i = 0; i < vecs.size(); i++) begin
      unique case (vecs[i].op)
        OP_SEND:     send_bits(make_frame(vecs[i].val, 1'b0, 1'b1), 11, 1'b0);
        OP_SEND_POP: send_bits(make_frame(vecs[i].val, 1'b0, 1'b1), 11, 1'b1);
        OP_BADPAR:   send_bits(make_frame(vecs[i].val, 1'b1, 1'b1), 11, 1'b0);
        OP_BADSTOP:  send_bits(make_frame(vecs[i].val, 1'b0, 1'b0), 11, 1'b0);
        default:     do_pop();
      endcase
      // Restore idle-high data after a bad-stop frame.
      ps2_data = 1'b1;
      check($sformatf("vec%0d", i), {kbd_ready, kbd_overflow, kbd_data},
            {vecs[i].exp_ready, vecs[i].exp_ovf, vecs[i].exp_data});
    end

    // --- timeout: start + 4 bits, stall, then a clean frame ---
    send_bits(make_frame(8'h7E, 1'b0, 1'b1), 5, 1'b0);
    ps2_data = 1'b1;
    repeat (TMO + 5) @(posedge clk);
    send_bits(make_frame(8'h2A, 1'b0, 1'b1), 11, 1'b0);
    check("timeout_recover", {kbd_ready, kbd_overflow, kbd_data}, {2'b10, 8'h2A});
    do_pop();
    check("timeout_only_one", {kbd_ready, kbd_overflow, kbd_data}, 10'h000);

    // --- async reset mid-frame with 3 bytes buffered ---
    send_bits(make_frame(8'h11, 1'b0, 1'b1), 11, 1'b0);
    send_bits(make_frame(8'h22, 1'b0, 1'b1), 11, 1'b0);
    send_bits(make_frame(8'h33, 1'b0, 1'b1), 11, 1'b0);
    check("pre_reset_head", {kbd_ready, kbd_overflow, kbd_data}, {2'b10, 8'h11});
    send_bits(make_frame(8'h44, 1'b0, 1'b1), 4, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_reset", {kbd_ready, kbd_overflow, kbd_data}, 10'h000);
    ps2_data = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    send_bits(make_frame(8'h55, 1'b0, 1'b1), 11, 1'b0);
    check("post_reset_frame", {kbd_ready, kbd_overflow, kbd_data}, {2'b10, 8'h55});
    do_pop();
    check("post_reset_empty", {kbd_ready, kbd_overflow, kbd_data}, 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_ps2_kbd_rx
